// File: rtl/mat4x4_mult_engine_if.sv
// Handshake and data bundle for the 4x4 matrix multiplier.
// The master drives start/operands; the slave returns C with done/busy.
interface mat4x4_mult_engine_if;
  logic          start;
  logic [1023:0] in_matrix;
  logic [511:0]  out_matrix;
  logic          done;
  logic          busy;

  modport master (
    output start,
    output in_matrix,
    input  out_matrix,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  in_matrix,
    output out_matrix,
    output done,
    output busy
  );
endinterface

// File: rtl/mat4x4_mult_engine.sv
// Sequential 4x4 signed matrix multiply, one MAC per cycle (C = A x B).
// Define MM_SATURATE_EN to clamp results instead of wrapping them.
module mat4x4_mult_engine #(
  parameter int ELEM_W = 32,
  parameter int ACC_W  = 66
) (
  input logic           clk,
  input logic           reset_n,
  mat4x4_mult_engine_if.slave mm
);
  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FLUSH,
    DONE
  } state_t;

  localparam int MW = 16 * ELEM_W;
  localparam int PW = 2 * ELEM_W;

  state_t state, state_nx;

  logic [MW-1:0] a_q, b_q, c_mat_q;
  logic [1:0]    row_q, col_q, k_q;
  logic signed [ACC_W-1:0]  acc_q, sum;
  logic signed [ELEM_W-1:0] a_el, b_el, res;
  logic signed [PW-1:0]     prod;
  logic accept, last;
  int a_idx, b_idx, c_idx;

`ifdef MM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-ELEM_W+1){1'b0}}, {(ELEM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-ELEM_W+1){1'b1}}, {(ELEM_W-1){1'b0}}};
`endif

  assign accept = mm.start &&
                  (state == IDLE || state == DONE);
  assign last   = &{row_q, col_q, k_q};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = COMPUTE;
      COMPUTE: if (last)   state_nx = FLUSH;
      FLUSH:   state_nx = DONE;
      DONE:    if (accept) state_nx = COMPUTE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mm.busy       = (state == COMPUTE);
    mm.done       = (state == DONE);
    mm.out_matrix = c_mat_q;
  end

  always_comb begin
    a_idx = 32'({row_q, k_q});
    b_idx = 32'({k_q, col_q});
    c_idx = 32'({row_q, col_q});
    a_el  = a_q[a_idx*ELEM_W +: ELEM_W];
    b_el  = b_q[b_idx*ELEM_W +: ELEM_W];
    prod  = a_el * b_el;
    sum   = (k_q == 2'd0 ? '0 : acc_q) +
            {{(ACC_W-PW){prod[PW-1]}}, prod};
`ifdef MM_SATURATE_EN
    if (sum > SAT_HI)      res = SAT_HI[ELEM_W-1:0];
    else if (sum < SAT_LO) res = SAT_LO[ELEM_W-1:0];
    else                   res = sum[ELEM_W-1:0];
`else
    res = sum[ELEM_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_mat_q <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
    end else if (accept) begin
      a_q   <= mm.in_matrix[MW-1:0];
      b_q   <= mm.in_matrix[2*MW-1:MW];
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
    end else if (state == COMPUTE) begin
      acc_q <= sum;
      {row_q, col_q, k_q} <= {row_q, col_q, k_q} + 6'd1;
      if (k_q == 2'd3)
        c_mat_q[c_idx*ELEM_W +: ELEM_W] <= res;
    end
  end
endmodule
